// File: rtl/scc_pkg.sv
// Shared definitions for the single-cycle core's instruction fetch path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package scc_pkg;

    localparam int PF_ADDR_W   = 32;
    localparam int PF_DATA_W   = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [PF_ADDR_W-1:0] PF_RESET_PC = 32'h0000_0000;

    // One prefetched instruction, tagged with the address it was fetched from.
    typedef struct packed {
        logic [PF_ADDR_W-1:0] addr;
        logic [PF_DATA_W-1:0] data;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO with head-of-queue peek and a one-cycle clear.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
//
// Ports: clk/reset (sync, active-high); clear empties the FIFO at the next edge;
// push/din write an entry; pop retires head; count/full/empty report occupancy.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !clear));

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher between variable-latency imem and the core fetch port.
// Latency: response -> core_valid one cycle (no bypass); flush -> first instr after 3 cycles.
// Backpressure: core_stall when the requested instr is absent; issue capped at DEPTH in flight.
//
// Ports: core_addr/core_en in, core_instr/core_valid/core_stall out (core side);
// mem_req/mem_addr out, mem_gnt/mem_rvalid/mem_rdata in (in-order memory side).
module inst_prefetch
    import scc_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = PF_ADDR_W,
    parameter int                DATA_W   = PF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = PF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_en,
    output logic [DATA_W-1:0] core_instr,
    output logic              core_valid,
    output logic              core_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH+1);
    // Discard counter is wider: back-to-back flushes can stack several windows of
    // abandoned requests on top of each other.
    localparam int DW = CW + 2;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            head, din;
    logic [CW-1:0]     count;
    logic              full, empty;

    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CW-1:0]     live_q, live_d;
    logic [DW-1:0]     disc_q, disc_d;

    logic              hit, flush, pop, push, drop, issue;
    logic [ADDR_W-1:0] expected;
    logic [CW:0]       inflight;

    assign hit      = ~empty & (head.addr == core_addr);
    // With an empty FIFO the next thing to arrive is tail_addr, so waiting on it
    // is a plain stall rather than a redirect.
    assign expected = empty ? tail_q : head.addr;
    assign flush    = ~reset & core_en & ~hit & (core_addr != expected);
    assign pop      = ~reset & core_en & hit;

    assign core_valid = ~reset & hit;
    assign core_stall = core_en & ~core_valid;
    assign core_instr = reset ? '0 : head.data;

    // Buffered plus live requests never exceed DEPTH, which is what keeps pushes
    // from ever meeting a full FIFO.
    assign inflight = {1'b0, count} + {1'b0, live_q};
    assign mem_req  = ~reset & ~flush & (inflight < (CW+1)'(DEPTH));
    assign mem_addr = fetch_q;
    assign issue    = mem_req & mem_gnt;

    assign drop = mem_rvalid & (disc_q != '0);
    assign push = ~reset & ~flush & mem_rvalid & ~drop;
    assign din  = '{addr: tail_q, data: mem_rdata};

    always_comb begin
        fetch_d = fetch_q;
        tail_d  = tail_q;
        live_d  = live_q;
        disc_d  = disc_q;
        if (flush) begin
            fetch_d = core_addr;
            tail_d  = core_addr;
            live_d  = '0;
            // Every live request becomes a discard; a response landing now retires
            // one of them (from disc first, else from live), hence the single -1.
            disc_d  = disc_q + DW'(live_q) - DW'(mem_rvalid);
        end else begin
            if (issue) fetch_d = fetch_q + STEP;
            if (push)  tail_d  = tail_q + STEP;
            live_d = live_q + CW'(issue) - CW'(push);
            disc_d = disc_q - DW'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q <= RESET_PC;
            tail_q  <= RESET_PC;
            live_q  <= '0;
            disc_q  <= '0;
        end else begin
            fetch_q <= fetch_d;
            tail_q  <= tail_d;
            live_q  <= live_d;
            disc_q  <= disc_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
- Instruction prefetch buffer between the variable-latency instruction memory and the single-cycle core's fetch port (in_mem_addr / in_mem_en / in_mem).
- Runs ahead sequentially, keeps up to DEPTH in-flight or buffered instructions, and serves the core from a FIFO.
- Raises core_stall when the requested instruction is not yet available. The core gates its clock with core_stall, the same way it gates it with halt.
- Flushes on any non-sequential core address, such as a branch.

Parameters:
- DEPTH, 4, FIFO entries; also the cap on buffered plus outstanding requests (power of 2, at least 2).
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first prefetch address after reset.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- core_addr  in  ADDR_W  address requested by the core (in_mem_addr).
- core_en  in  1  core fetch request (in_mem_en).
- core_instr  out  DATA_W  instruction for core_addr (drives in_mem).
- core_valid  out  1  core_instr is valid for core_addr this cycle.
- core_stall  out  1  core_en & ~core_valid.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  ADDR_W  fetch address.
- mem_gnt  in  1  request accepted this cycle (meaningful only while mem_req=1).
- mem_rvalid  in  1  read data valid; responses return in request order.
- mem_rdata  in  DATA_W  read data.

Behaviour:
State:
- FIFO of {addr, data} entries, with count.
- fetch_addr: next address to issue.
- tail_addr: address of the next response.
- live_cnt: outstanding requests whose data will be kept.
- disc_cnt: outstanding requests whose data will be dropped.

Reset (sync):
- count, live_cnt and disc_cnt are 0.
- fetch_addr and tail_addr are RESET_PC.
- While reset=1: mem_req=0, core_valid=0, core_stall=core_en, core_instr=0.

Hit and flush:
- hit = count>0 & head.addr==core_addr.
- core_valid=hit; core_instr=head.data.
- expected = head.addr if count>0, else tail_addr.
- flush = core_en & ~hit & (core_addr != expected).
- A miss with core_addr==expected and count==0 is a plain wait, not a flush.

Pop:
- core_en & hit pops the head at the clock edge.
- The core must hold core_addr stable while stalled.

Issue:
- mem_req = ~reset & ~flush & (count + live_cnt < DEPTH); mem_addr = fetch_addr.
- mem_req & mem_gnt: fetch_addr += 4 (modulo 2^ADDR_W, wraps at 0xFFFF_FFFC to 0); live_cnt++.
- A request may be withdrawn (mem_req dropped before gnt) on flush or reset.

Response:
- mem_rvalid & disc_cnt>0: drop the data; disc_cnt--.
- Otherwise push {tail_addr, mem_rdata}; tail_addr += 4; live_cnt--.
- The space invariant guarantees the FIFO never overflows. An assertion must flag a push when full.

Flush cycle:
- count <= 0.
- A response arriving in the flush cycle is dropped.
- disc_cnt <= disc_cnt + live_cnt - (mem_rvalid ? 1 : 0), counting this cycle's dropped response against disc_cnt first if disc_cnt was greater than 0.
- live_cnt <= 0; fetch_addr <= core_addr; tail_addr <= core_addr.
- No issue in the flush cycle.

Simultaneous events:
- Push and pop in the same cycle: count unchanged.
- No bypass: a response becomes core_valid the cycle after mem_rvalid.

Latency:
- Flush at cycle T, with zero-wait memory (gnt at request, rvalid the next cycle): request at T+1, rvalid at T+2, core_valid at T+3.
- Steady sequential stream: one instruction per cycle.

core_en=0: no pop and no flush; prefetch continues until the FIFO is full.

Reset mid-operation:
- All counters are cleared.
- Instruction memory shares the same reset. A response to a pre-reset request is a protocol violation, and a bench assertion must flag it.

Decomposition:
- Shared package scc_pkg holds:
  - ADDR_W and DATA_W defaults.
  - INSTR_BYTES=4.
  - RESET_PC.
  - A typedef for the prefetch entry {addr, data}.
- One sub-module, prefetch_fifo: a synchronous DEPTH-entry FIFO with push, pop, head, count and full/empty, all on clk with sync reset.
- Counters, flush logic and the memory handshake stay in inst_prefetch.

Test Plan:
- Reset: hold reset 2 cycles with core_en=1 -> mem_req=0, core_valid=0, core_stall=1. First cycle after release -> mem_req=1, mem_addr=0x0.
- Sequential stream, zero-wait memory: core_addr steps 0,4,8,... after warm-up -> core_valid=1 every cycle, core_instr=mem[core_addr], no stalls.
- Full: core_en=0, memory always granting -> exactly 4 grants (0x0..0xC), then mem_req=0 with count=4. Then core_en=1 at 0x0 -> pops resume issue at 0x10.
- Branch with outstanding requests: 0x10 and 0x14 outstanding, count=0, core_addr=0x100 -> flush. Responses for 0x10/0x14 are dropped (disc_cnt 2 -> 0). mem_addr=0x100 next cycle; core_instr=mem[0x100] at T+3.
- Flush-cycle response: mem_rvalid arrives in the same cycle core_addr jumps to 0x200 -> that data is not pushed, and the first valid instruction is mem[0x200].
- Wrap: RESET_PC=0xFFFF_FFF8 -> mem_addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and core hits at each address in order.
